bcd_updown_counter: RTL and testbench
=====================================

// Module: bcd_updown_counter
// PURPOSE
//  Parametrised N-digit packed-BCD up/down counter with parallel load, wrap or saturate mode and cascade carry.
//  Generalises the fixed 3-digit up-only BCD chain: one block, DIGITS wide, and counts in both directions.
//  Sits behind the keypad/display path. Drives 7-seg decoders directly.
//  carry_out allows a further counter to cascade for wider counts.
// PARAMETERS
//  DIGITS    3  number of BCD digits (>=1); count width = 4*DIGITS
//  SATURATE  0  0: wrap at terminal value; 1: hold at terminal value
// PORTS
//  clk         in   1          rising-edge clock
//  reset       in   1          synchronous, active-high reset
//  en          in   1          count enable; one step per clk while high
//  up          in   1          direction: 1 = increment, 0 = decrement
//  load        in   1          parallel load strobe
//  load_val    in   4*DIGITS   packed BCD load value, digit0 = [3:0]
//  count       out  4*DIGITS   packed BCD count, digit0 = [3:0]
//  carry_out   out  1          comb: en & terminal (up: all 9s; down: all 0s)
//  wrap_pulse  out  1          reg: 1-cycle pulse after a wrap or saturate event
//  load_err    out  1          reg: 1-cycle pulse after a load that held an illegal digit (>9)
// BEHAVIOUR
//  - One clock, clk; reset is synchronous and active-high. No async paths.
//  - Reset: count=0, wrap_pulse=0, load_err=0. carry_out follows count/en/up combinationally.
//  - Priority each edge: reset > load > en. Outputs are idle when en=0 and load=0.
//  - load: count <= load_val next edge (1-cycle latency); en ignored that cycle.
//  - Load digit check: any digit >9 is stored as 0 and load_err=1 next cycle. Legal digits load unchanged.
//  - Up step: digit0 increments. Digit k increments iff all lower digits ==9; digits that were 9 become 0.
//  - Down step: digit0 decrements. Digit k decrements iff all lower digits ==0; digits that were 0 become 9.
//  - Terminal: up & count==all 9s, or !up & count==0.
//    - SATURATE=0: up wraps to 0; down wraps to all 9s.
//    - SATURATE=1: count holds.
//    - Either mode: wrap_pulse=1 the cycle after the step.
//  - carry_out = en & !load & terminal. It is combinational and is the cascade enable for the next block.
//  - Direction change: up may toggle on any cycle and takes effect on the same edge. No pipeline, no dead cycle.
//  - Reset mid-operation: clears count and pulses on that edge and overrides a simultaneous load or en.
//  - count never holds a digit >9 (invariant; assert in sim).
// STRUCTURE
//  - Package bcd_pkg: BCD_MAX=4'd9, BCD_MIN=4'd0, function is_bcd(d), typedef bcd_digit_t logic[3:0].
//  - Sub-module bcd_digit, instantiated DIGITS times via generate:
//    - inputs clk, reset, step, up, load, ld_digit
//    - outputs digit, at_max, at_min
//  - Carry chains:
//    - up_chain[k] = &at_max[k-1:0]
//    - dn_chain[k] = &at_min[k-1:0]
//    - step[k] = en & (up ? up_chain[k] : dn_chain[k]) & !(SATURATE & terminal)
// TESTING (DIGITS=3 unless noted)
//  1. reset=1 with en=1, load=1 for 2 cycles -> count=000, wrap_pulse=0, load_err=0.
//  2. Load 0x198, then en=1 up=1 for 3 cycles -> 199, 200, 201; no carry_out.
//  3. Load 0x999, en=1 up=1, SATURATE=0 -> carry_out=1 pre-edge; count=000; wrap_pulse=1 for one cycle.
//     With SATURATE=1 -> count stays 999; wrap_pulse=1.
//  4. Load 0x100, en=1 up=0 -> 099, 098.
//     Then load 0x000 and step down -> 999 with wrap_pulse=1 (SATURATE=0).
//  5. Load 0x1A5 -> count=105, load_err=1 for exactly one cycle.
//     load=1 and en=1 in the same cycle -> load wins.
//  6. DIGITS=4: up-count from 0 for 10000 cycles -> exactly one wrap.
//     Check count==0, wrap_pulse count==1 and the digit<=9 assertion holds throughout.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limits and legality check for the packed-BCD counter blocks.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic is_bcd(input bcd_digit_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the up/down counter: load with illegal-digit scrub, single up/down step.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       up,
  input  logic       load,
  input  bcd_digit_t ld_digit,
  output bcd_digit_t digit,
  output logic       at_max,
  output logic       at_min
);

  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= BCD_MIN;
    end else if (load) begin
      // Illegal digits are scrubbed to zero so count always stays valid BCD.
      digit <= is_bcd(ld_digit) ? ld_digit : BCD_MIN;
    end else if (step) begin
      if (up) begin
        digit <= at_max ? BCD_MIN : digit + 4'd1;
      end else begin
        digit <= at_min ? BCD_MAX : digit - 4'd1;
      end
    end
  end

  assign at_max = (digit == BCD_MAX);
  assign at_min = (digit == BCD_MIN);

  digit_is_bcd: assert property (@(posedge clk) disable iff (reset) is_bcd(digit));

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit packed-BCD up/down counter with parallel load, wrap/saturate mode and cascade carry.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned SATURATE = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                carry_out,
  output logic                wrap_pulse,
  output logic                load_err
);

  localparam bit Sat = (SATURATE != 0);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] up_chain;
  logic [DIGITS-1:0] dn_chain;
  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] ld_ok;
  logic              terminal;
  logic              hold;

  assign terminal  = up ? (&at_max) : (&at_min);
  assign hold      = Sat & terminal;
  assign carry_out = en & ~load & terminal;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    if (k == 0) begin : g_lsd
      assign up_chain[k] = 1'b1;
      assign dn_chain[k] = 1'b1;
    end else begin : g_upper
      // Ripple form of &at_max[k-1:0] / &at_min[k-1:0].
      assign up_chain[k] = up_chain[k-1] & at_max[k-1];
      assign dn_chain[k] = dn_chain[k-1] & at_min[k-1];
    end

    assign step[k]  = en & (up ? up_chain[k] : dn_chain[k]) & ~hold;
    assign ld_ok[k] = is_bcd(load_val[4*k +: 4]);

    bcd_digit u_digit (
      .clk      (clk),
      .reset    (reset),
      .step     (step[k]),
      .up       (up),
      .load     (load),
      .ld_digit (load_val[4*k +: 4]),
      .digit    (count[4*k +: 4]),
      .at_max   (at_max[k]),
      .at_min   (at_min[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_pulse <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      wrap_pulse <= carry_out;
      load_err   <= load & ~(&ld_ok);
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter: 3-digit wrap and saturate instances, 4-digit wrap run.
module tb_bcd_updown_counter;

  typedef struct packed {
    logic [11:0] cnt;
    logic        wp;
    logic        le;
  } exp_t;

  logic        clk;
  logic        reset, en, up, load;
  logic [11:0] load_val;
  logic [11:0] count_w, count_s;
  logic        carry_w, carry_s, wrap_w, wrap_s, lerr_w, lerr_s;

  logic        reset4, en4, up4, load4;
  logic [15:0] load_val4;
  logic [15:0] count4;
  logic        carry4, wrap4, lerr4;

  int   n_checks;
  int   n_errors;
  int   mw, ms;
  exp_t q_w[$];
  exp_t q_s[$];

  bcd_updown_counter #(.DIGITS(3), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count_w), .carry_out(carry_w), .wrap_pulse(wrap_w), .load_err(lerr_w)
  );

  bcd_updown_counter #(.DIGITS(3), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count_s), .carry_out(carry_s), .wrap_pulse(wrap_s), .load_err(lerr_s)
  );

  bcd_updown_counter #(.DIGITS(4), .SATURATE(0)) u_four (
    .clk(clk), .reset(reset4), .en(en4), .up(up4), .load(load4), .load_val(load_val4),
    .count(count4), .carry_out(carry4), .wrap_pulse(wrap4), .load_err(lerr4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd3(input int n);
    logic [3:0] d2, d1, d0;
    d2 = 4'(n / 100);
    d1 = 4'((n / 10) % 10);
    d0 = 4'(n % 10);
    return {d2, d1, d0};
  endfunction

  // Decimal reference model: the counter value is kept as a plain integer 0..999.
  task automatic model(input int cur, input bit sat, input logic r, input logic e,
                       input logic u, input logic l, input logic [11:0] lv,
                       output int nxt, output logic wp, output logic le);
    bit term;
    int pw;
    int d;
    term = u ? (cur == 999) : (cur == 0);
    nxt  = cur;
    wp   = 1'b0;
    le   = 1'b0;
    if (r) begin
      nxt = 0;
    end else if (l) begin
      nxt = 0;
      pw  = 1;
      for (int k = 0; k < 3; k++) begin
        d = int'(lv[4*k +: 4]);
        if (d > 9) begin
          le = 1'b1;
          d  = 0;
        end
        nxt += d * pw;
        pw  *= 10;
      end
    end else if (e) begin
      wp = term;
      if (term && sat) nxt = cur;
      else if (u)      nxt = (cur + 1) % 1000;
      else             nxt = (cur + 999) % 1000;
    end
  endtask

  // One clock of shared stimulus: check pre-edge carry, push expectations, compare after edge.
  task automatic cyc(input logic r, input logic e, input logic u, input logic l,
                     input logic [11:0] lv);
    exp_t ew, es, gw, gs;
    int   nw, ns;
    logic tw, ts;
    reset = r; en = e; up = u; load = l; load_val = lv;
    #1;
    tw = u ? (mw == 999) : (mw == 0);
    ts = u ? (ms == 999) : (ms == 0);
    check_eq("carry_wrap", carry_w, e & ~l & tw);
    check_eq("carry_sat", carry_s, e & ~l & ts);
    model(mw, 1'b0, r, e, u, l, lv, nw, ew.wp, ew.le);
    model(ms, 1'b1, r, e, u, l, lv, ns, es.wp, es.le);
    ew.cnt = to_bcd3(nw);
    es.cnt = to_bcd3(ns);
    mw = nw;
    ms = ns;
    q_w.push_back(ew);
    q_s.push_back(es);
    @(posedge clk);
    #1;
    gw = q_w.pop_front();
    gs = q_s.pop_front();
    check_eq("count_wrap", count_w, gw.cnt);
    check_eq("wrap_pulse_wrap", wrap_w, gw.wp);
    check_eq("load_err_wrap", lerr_w, gw.le);
    check_eq("count_sat", count_s, gs.cnt);
    check_eq("wrap_pulse_sat", wrap_s, gs.wp);
    check_eq("load_err_sat", lerr_s, gs.le);
  endtask

  initial begin
    int          wraps;
    logic [11:0] lv;
    n_checks = 0;
    n_errors = 0;
    mw = 0;
    ms = 0;
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    reset4 = 1'b1; en4 = 1'b0; up4 = 1'b1; load4 = 1'b0; load_val4 = '0;

    // Reset dominates load and en.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 12'h555);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 12'h555);

    // Up through a decade boundary.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 12'h198);
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);

    // Up terminal: wrap vs saturate, pulse lasts one cycle.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 12'h999);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);

    // Down across borrow, then down terminal.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 12'h100);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);

    // Illegal digit scrub, then load beating en.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 12'h1A5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 12'h321);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 12'hFFF);

    // Same-edge direction change and reset mid-operation.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 12'h500);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 12'h777);

    // Random mix, biased toward terminal loads.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0:       lv = 12'h999;
        1:       lv = 12'h000;
        default: lv = 12'($urandom_range(0, 4095));
      endcase
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), lv);
    end

    // Four digits: a full 10000-step cycle wraps exactly once.
    reset4 = 1'b0;
    en4    = 1'b1;
    wraps  = 0;
    for (int i = 1; i <= 10000; i++) begin
      @(posedge clk);
      #1;
      if (wrap4) wraps++;
      if (i == 9999) begin
        check_eq("count4_at_9999", count4, 16'h9999);
        check_eq("carry4_at_9999", carry4, 1'b1);
      end
    end
    check_eq("count4_after_wrap", count4, 16'h0000);
    check_eq("wraps4", wraps, 1);
    check_eq("wrap4_pulse", wrap4, 1'b1);
    en4 = 1'b0;
    @(posedge clk);
    #1;
    check_eq("wrap4_clears", wrap4, 1'b0);
    check_eq("count4_idle", count4, 16'h0000);
    check_eq("load_err4", lerr4, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
